muldiv_unit: RTL

- Iterative multiply/divide unit holding the HI/LO register pair.
- Sits in the execute stage, directly downstream of the register file's two read ports (a = rd1, b = rd2).
- Executes MULT, MULTU, DIV and DIVU as multi-cycle operations, and serves MFHI/MFLO/MTHI/MTLO.
- Control logic stalls on busy; HI/LO results feed the writeback mux.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between execute-stage control and the HI/LO multiply/divide unit.
// Control drives the master side; the unit itself sits on the slave side.
interface muldiv_unit_if #(
   parameter int WORD_SIZE = 32
);
   logic                 start;
   logic [1:0]           op;
   logic [WORD_SIZE-1:0] a;
   logic [WORD_SIZE-1:0] b;
   logic                 mthi;
   logic                 mtlo;
   logic [WORD_SIZE-1:0] hi;
   logic [WORD_SIZE-1:0] lo;
   logic                 busy;
   logic                 done;

   modport master (
      output start, op, a, b, mthi, mtlo,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Operands are turned into magnitudes on entry, signs are reapplied in a single FIX cycle.
module muldiv_unit #(
   parameter int WORD_SIZE = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);
   localparam int W  = WORD_SIZE;
   localparam int CW = $clog2(WORD_SIZE) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic           is_div_q, is_div_d;
   logic           neg_res_q, neg_res_d;
   logic           neg_rem_q, neg_rem_d;
   logic           b_zero_q, b_zero_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic           done_q, done_d;

   logic           is_signed;
   logic           sgn_a, sgn_b;
   logic [W-1:0]   mag_a, mag_b;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_trial;
   logic [2*W-1:0] div_next;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo, rem;
   logic           last_step;

   assign is_signed = ~bus.op[0];
   assign sgn_a     = is_signed & bus.a[W-1];
   assign sgn_b     = is_signed & bus.b[W-1];
   assign mag_a     = sgn_a ? -bus.a : bus.a;
   assign mag_b     = sgn_b ? -bus.b : bus.b;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                              : {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};

   // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
   assign div_trial = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
   assign div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                   : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

   assign prod      = neg_res_q ? -acc_q : acc_q;
   // A zero divisor leaves quotient all ones; it must not be negated.
   assign quo       = (neg_res_q && !b_zero_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
   assign rem       = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
   assign last_step = (cnt_q == CW'(W - 1));

   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      b_zero_d  = b_zero_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               is_div_d  = bus.op[1];
               neg_res_d = sgn_a ^ sgn_b;
               neg_rem_d = sgn_a;
               b_zero_d  = (bus.b == '0);
               opnd_d    = bus.op[1] ? mag_b : mag_a;
               acc_d     = {{W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
               cnt_d     = '0;
               state_d   = CALC;
            end else begin
               if (bus.mthi) hi_d = bus.a;
               if (bus.mtlo) lo_d = bus.a;
            end
         end
         CALC: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (last_step) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) begin
               hi_d = rem;
               lo_d = quo;
            end else begin
               hi_d = prod[2*W-1:W];
               lo_d = prod[W-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_zero_q  <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         b_zero_q  <= b_zero_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
endmodule
